// File: rtl/multi_stepped_counter.sv
// NCH independent tap-divided step counters with wrap or saturate modes.
// Optional preload ports (ld, ld_val) are built when MULTI_STEPPED_COUNTER_PRELOAD_EN is defined.
module multi_stepped_counter #(
   parameter int NCH   = 4,
   parameter int CW    = 8,
   parameter int SW    = 4,
   parameter int NTAPS = 6,
   parameter int TSW   = 3,
   parameter int DIVW  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NTAPS-1:0]  taps,
   input  logic [NCH-1:0]    en,
   input  logic [NCH-1:0]    clr,
   input  logic [NCH-1:0]    dir,
   input  logic [NCH-1:0]    sat,
   input  logic [NCH*TSW-1:0]  tap_sel,
   input  logic [NCH*DIVW-1:0] period,
   input  logic [NCH*SW-1:0]   step,
`ifdef MULTI_STEPPED_COUNTER_PRELOAD_EN
   input  logic [NCH-1:0]    ld,
   input  logic [NCH*CW-1:0] ld_val,
`endif
   output logic [NCH*CW-1:0] ctr,
   output logic [NCH-1:0]    upd,
   output logic [NCH-1:0]    ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam int TN = 2 ** TSW;

   logic [1:0]      st_q  [NCH];
   logic [1:0]      st_d  [NCH];
   logic [DIVW-1:0] div_q [NCH];
   logic [DIVW-1:0] div_d [NCH];
   logic [CW-1:0]   ctr_q [NCH];
   logic [CW-1:0]   ctr_d [NCH];
   logic [CW:0]     res   [NCH];
   logic [NCH-1:0]  upd_q, upd_d, ovf_q, ovf_d, tev;
   logic [TN-1:0]   taps_x;

   // Zero-extended taps: out-of-range selects read 0 and stall the channel
   assign taps_x = TN'(taps);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         tev[i] = taps_x[tap_sel[i*TSW +: TSW]];
         if (dir[i])
            res[i] = {1'b0, ctr_q[i]} - (CW+1)'(step[i*SW +: SW]);
         else
            res[i] = {1'b0, ctr_q[i]} + (CW+1)'(step[i*SW +: SW]);
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         st_d[i]  = st_q[i];
         div_d[i] = div_q[i];
         ctr_d[i] = ctr_q[i];
         upd_d[i] = 1'b0;
         ovf_d[i] = 1'b0;
         if (clr[i]) begin
            ctr_d[i] = '0;
            div_d[i] = '0;
            st_d[i]  = en[i] ? S_RUN : S_IDLE;
`ifdef MULTI_STEPPED_COUNTER_PRELOAD_EN
         end else if (ld[i]) begin
            ctr_d[i] = ld_val[i*CW +: CW];
            div_d[i] = '0;
            st_d[i]  = en[i] ? S_RUN : S_IDLE;
`endif
         end else begin
            case (st_q[i])
               S_IDLE: if (en[i]) st_d[i] = S_RUN;
               S_RUN: begin
                  if (!en[i]) begin
                     st_d[i] = S_IDLE;
                  end else if (tev[i]) begin
                     if (div_q[i] >= period[i*DIVW +: DIVW]) begin
                        div_d[i] = '0;
                        upd_d[i] = 1'b1;
                        ctr_d[i] = res[i][CW-1:0];
                        if (res[i][CW]) begin
                           ovf_d[i] = 1'b1;
                           if (sat[i]) begin
                              ctr_d[i] = dir[i] ? '0 : '1;
                              st_d[i]  = S_HOLD;
                           end
                        end
                     end else begin
                        div_d[i] = div_q[i] + DIVW'(1);
                     end
                  end
               end
               S_HOLD: if (!sat[i]) st_d[i] = en[i] ? S_RUN : S_IDLE;
               default: st_d[i] = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i]  <= S_IDLE;
            div_q[i] <= '0;
            ctr_q[i] <= '0;
         end
         upd_q <= '0;
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            st_q[i]  <= st_d[i];
            div_q[i] <= div_d[i];
            ctr_q[i] <= ctr_d[i];
         end
         upd_q <= upd_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) ctr[i*CW +: CW] = ctr_q[i];
   end

   assign upd = upd_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_multi_stepped_counter.sv
// Scoreboard bench for multi_stepped_counter: directed steps push expected
// values, a negedge monitor pops and compares on every upd/ovf pulse.
module tb_multi_stepped_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  taps;
   logic [3:0]  en, clr, dir, sat;
   logic [11:0] tap_sel;
   logic [31:0] period;
   logic [15:0] step;
   logic [31:0] ctr;
   logic [3:0]  upd, ovf;
`ifdef MULTI_STEPPED_COUNTER_PRELOAD_EN
   logic [3:0]  ld;
   logic [31:0] ld_val;
`endif

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] v;
      logic       o;
   } exp_t;

   exp_t sbq[$];
   int applied = 0;
   int miscmp  = 0;

   multi_stepped_counter dut (
      .clk(clk), .rst(rst), .taps(taps), .en(en), .clr(clr),
      .dir(dir), .sat(sat), .tap_sel(tap_sel), .period(period),
      .step(step),
`ifdef MULTI_STEPPED_COUNTER_PRELOAD_EN
      .ld(ld), .ld_val(ld_val),
`endif
      .ctr(ctr), .upd(upd), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ctr_of(input int c);
      return ctr[c*8 +: 8];
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [5:0] m);
      taps = m;
      tick(1);
      taps = '0;
   endtask

   task automatic cfg(input int c, input logic [2:0] ts, input logic [7:0] p,
                      input logic [3:0] s, input logic d, input logic sa);
      tap_sel[c*3 +: 3] = ts;
      period[c*8 +: 8]  = p;
      step[c*4 +: 4]    = s;
      dir[c]            = d;
      sat[c]            = sa;
   endtask

   task automatic expect_step(input int c, input logic [7:0] v, input logic o);
      exp_t e;
      e.ch = 2'(c);
      e.v  = v;
      e.o  = o;
      sbq.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      applied++;
      if (act !== req) begin
         miscmp++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Monitor: every upd or ovf pulse must match the next queued expectation
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int c = 0; c < 4; c++) begin
            if (upd[c] || ovf[c]) begin
               applied++;
               if (sbq.size() == 0) begin
                  miscmp++;
                  $display("FAIL unexpected_pulse ch%0d: got ctr=%h upd=%b ovf=%b want no pulse",
                           c, ctr_of(c), upd[c], ovf[c]);
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  if (e.ch != 2'(c) || e.v !== ctr_of(c) || e.o !== ovf[c] || upd[c] !== 1'b1) begin
                     miscmp++;
                     $display("FAIL step ch%0d: got ctr=%h upd=%b ovf=%b want ch%0d ctr=%h upd=1 ovf=%b",
                              c, ctr_of(c), upd[c], ovf[c], e.ch, e.v, e.o);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; taps = '0; en = '0; clr = '0; dir = '0; sat = '0;
      tap_sel = '0; period = '0; step = '0;
`ifdef MULTI_STEPPED_COUNTER_PRELOAD_EN
      ld = '0; ld_val = '0;
`endif
      #12;
      chk("reset_ctr", ctr, 32'h0);
      chk("reset_upd", {28'h0, upd}, 32'h0);
      chk("reset_ovf", {28'h0, ovf}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Period 2 -> step every 3rd tap event
      cfg(0, 3'd0, 8'd2, 4'd3, 1'b0, 1'b0);
      en = 4'b0001;
      tick(2);
      for (int k = 1; k <= 9; k++) begin
         if (k % 3 == 0) expect_step(0, 8'(k), 1'b0);
         pulse(6'b000001);
         tick(3);
      end
      chk("period_final", {24'h0, ctr_of(0)}, 32'h9);

      // Clear on ch1 while ch0 and ch2 step
      cfg(0, 3'd0, 8'd0, 4'd1, 1'b0, 1'b0);
      cfg(1, 3'd0, 8'd0, 4'd1, 1'b0, 1'b0);
      cfg(2, 3'd1, 8'd0, 4'd2, 1'b0, 1'b0);
      en = 4'b0111;
      tick(2);
      expect_step(0, 8'h0A, 1'b0);
      expect_step(1, 8'h01, 1'b0);
      expect_step(2, 8'h02, 1'b0);
      pulse(6'b000011);
      tick(1);
      expect_step(0, 8'h0B, 1'b0);
      expect_step(2, 8'h04, 1'b0);
      clr = 4'b0010;
      pulse(6'b000011);
      clr = '0;
      tick(1);
      chk("clr_ch1", {24'h0, ctr_of(1)}, 32'h0);

      // ch3 to 0x37 then async reset mid-cycle
      cfg(3, 3'd2, 8'd0, 4'd11, 1'b0, 1'b0);
      en = 4'b1111;
      tick(2);
      for (int k = 1; k <= 5; k++) begin
         expect_step(3, 8'(11 * k), 1'b0);
         pulse(6'b000100);
         tick(1);
      end
      chk("pre_rst_ch3", {24'h0, ctr_of(3)}, 32'h37);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ctr", ctr, 32'h0);
      chk("async_rst_upd", {28'h0, upd}, 32'h0);
      chk("async_rst_ovf", {28'h0, ovf}, 32'h0);
      en = '0; tap_sel = '0; period = '0; step = '0; dir = '0; sat = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Wrap down/up
      cfg(0, 3'd0, 8'd0, 4'd2, 1'b1, 1'b0);
      en = 4'b0001;
      tick(2);
      expect_step(0, 8'hFE, 1'b1); pulse(6'b000001); tick(1);
      cfg(0, 3'd0, 8'd0, 4'd5, 1'b0, 1'b0);
      expect_step(0, 8'h03, 1'b1); pulse(6'b000001); tick(1);
      cfg(0, 3'd0, 8'd0, 4'd1, 1'b1, 1'b0);
      expect_step(0, 8'h02, 1'b0); pulse(6'b000001); tick(1);
      cfg(0, 3'd0, 8'd0, 4'd4, 1'b1, 1'b0);
      expect_step(0, 8'hFE, 1'b1); pulse(6'b000001); tick(1);

      // Saturate up from 0xFC, hold, then resume in wrap
      cfg(0, 3'd0, 8'd0, 4'd2, 1'b1, 1'b0);
      expect_step(0, 8'hFC, 1'b0); pulse(6'b000001); tick(1);
      cfg(0, 3'd0, 8'd0, 4'd4, 1'b0, 1'b1);
      expect_step(0, 8'hFF, 1'b1); pulse(6'b000001); tick(1);
      for (int k = 0; k < 10; k++) begin
         pulse(6'b000001);
         tick(1);
      end
      chk("hold_ctr", {24'h0, ctr_of(0)}, 32'hFF);
      sat[0] = 1'b0;
      tick(1);
      expect_step(0, 8'h03, 1'b1); pulse(6'b000001); tick(1);

      // Land exactly on 0 (no saturation), then saturate down, clr exits HOLD
      cfg(0, 3'd0, 8'd0, 4'd3, 1'b1, 1'b1);
      expect_step(0, 8'h00, 1'b0); pulse(6'b000001); tick(1);
      cfg(0, 3'd0, 8'd0, 4'd1, 1'b1, 1'b1);
      expect_step(0, 8'h00, 1'b1); pulse(6'b000001); tick(1);
      pulse(6'b000001); tick(1);
      clr = 4'b0001;
      tick(1);
      clr = '0;
      cfg(0, 3'd0, 8'd0, 4'd1, 1'b0, 1'b1);
      expect_step(0, 8'h01, 1'b0); pulse(6'b000001); tick(1);

      // Out-of-range tap select stalls
      cfg(0, 3'd7, 8'd0, 4'd1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         pulse(6'h3F);
         tick(1);
      end
      chk("tsel7_frozen", {24'h0, ctr_of(0)}, 32'h01);

      // Lower period 9 -> 1 with div_cnt at 5
      cfg(0, 3'd0, 8'd9, 4'd1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         pulse(6'b000001);
         tick(1);
      end
      chk("per9_no_step", {24'h0, ctr_of(0)}, 32'h01);
      cfg(0, 3'd0, 8'd1, 4'd1, 1'b0, 1'b0);
      expect_step(0, 8'h02, 1'b0); pulse(6'b000001); tick(1);

      // en drop holds ctr and div_cnt
      cfg(0, 3'd0, 8'd3, 4'd1, 1'b0, 1'b0);
      pulse(6'b000001); tick(1);
      pulse(6'b000001); tick(1);
      en = '0;
      tick(1);
      for (int k = 0; k < 3; k++) begin
         pulse(6'b000001);
         tick(1);
      end
      chk("en_drop_hold", {24'h0, ctr_of(0)}, 32'h02);
      en = 4'b0001;
      tick(2);
      pulse(6'b000001); tick(1);
      expect_step(0, 8'h03, 1'b0); pulse(6'b000001); tick(1);

`ifdef MULTI_STEPPED_COUNTER_PRELOAD_EN
      cfg(0, 3'd0, 8'd0, 4'd4, 1'b1, 1'b1);
      expect_step(0, 8'h00, 1'b1); pulse(6'b000001); tick(1);
      ld_val[7:0] = 8'h80;
      ld = 4'b0001;
      tick(1);
      ld = '0;
      chk("preload_val", {24'h0, ctr_of(0)}, 32'h80);
      cfg(0, 3'd0, 8'd0, 4'd1, 1'b0, 1'b1);
      expect_step(0, 8'h81, 1'b0); pulse(6'b000001); tick(1);
      ld = 4'b0001;
      clr = 4'b0001;
      tick(1);
      ld = '0;
      clr = '0;
      chk("ld_clr_prio", {24'h0, ctr_of(0)}, 32'h00);
`endif

      tick(3);
      chk("sb_drained", sbq.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
      $finish;
   end

endmodule
